im_arbiter: RTL and testbench

IM_ARBITER -- requirements
Module: im_arbiter

---
 rtl/dpa_pkg.sv | 27 ++
 rtl/rr_pick2.sv | 111 +++++++++++
 rtl/im_arbiter.sv | 78 +++++++
 tb/tb_im_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpa_pkg.sv
// dpa_pkg: shared widths, arbiter state encodings and memory write-enable polarity.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dpa_pkg;

  localparam int IM_AW = 20;
  localparam int IM_DW = 24;

  // Arbiter FSM: nobody owns the port, or requester 0 / 1 owns it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  // Image memory write enable is active low.
  localparam logic IM_WEN_WRITE = 1'b0;
  localparam logic IM_WEN_READ  = 1'b1;

  // One requester's transfer command as presented to the arbiter.
  typedef struct packed {
    logic             we;
    logic [IM_AW-1:0] addr;
    logic [IM_DW-1:0] wdata;
  } im_req_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick with a burst cap on consecutive grants.
// Latency: grants are combinational from state, burst count and both requests.
// Backpressure: an ungranted requester simply waits; at most one grant per cycle.
// Ports: clk, reset (sync, active high); req0/req1 requests in; gnt0/gnt1 grants out.
module rr_pick2
  import dpa_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  // 1 when requester 1 was granted most recently; reset value makes r0 win the first tie.
  logic             last_gnt, last_nxt;

  // Saturating increment: an owner with no competitor keeps streaming at the cap.
  assign cnt_inc = (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      last_gnt  <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
      last_gnt  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = burst_cnt;
    last_nxt  = last_gnt;
    gnt0      = 1'b0;
    gnt1      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req0 && (!req1 || last_gnt)) begin
          gnt0      = 1'b1;
          state_nxt = ST_OWN0;
          cnt_nxt   = CNT_ONE;
          last_nxt  = 1'b0;
        end else if (req1) begin
          gnt1      = 1'b1;
          state_nxt = ST_OWN1;
          cnt_nxt   = CNT_ONE;
          last_nxt  = 1'b1;
        end
      end

      ST_OWN0: begin
        if (req0 && (!req1 || burst_cnt < CNT_MAX)) begin
          gnt0     = 1'b1;
          cnt_nxt  = cnt_inc;
          last_nxt = 1'b0;
        end else if (req1) begin
          // Hand over in the same cycle so the memory port never idles.
          gnt1      = 1'b1;
          state_nxt = ST_OWN1;
          cnt_nxt   = CNT_ONE;
          last_nxt  = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end

      ST_OWN1: begin
        if (req1 && (!req0 || burst_cnt < CNT_MAX)) begin
          gnt1     = 1'b1;
          cnt_nxt  = cnt_inc;
          last_nxt = 1'b1;
        end else if (req0) begin
          gnt0      = 1'b1;
          state_nxt = ST_OWN0;
          cnt_nxt   = CNT_ONE;
          last_nxt  = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Grants must never escape while reset is held.
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

endmodule

// File: rtl/im_arbiter.sv
// im_arbiter: shares one single-port image memory between the copy engine (r0) and overlay writer (r1).
// Latency: grant combinational; IM_A/IM_D/IM_WEN one cycle after handshake; rN_rvalid two cycles after.
// Backpressure: an ungranted requester holds req/we/addr/wdata until rN_gnt; one transfer per cycle.
// Ports: clk, reset (sync, active high); per requester rN_req/rN_we/rN_addr/rN_wdata in,
//        rN_gnt/rN_rvalid out; rdata mirrors IM_Q; IM_A/IM_D/IM_WEN drive memory, IM_Q returns data.
module im_arbiter
  import dpa_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic [IM_AW-1:0] r0_addr,
  input  logic [IM_DW-1:0] r0_wdata,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic [IM_AW-1:0] r1_addr,
  input  logic [IM_DW-1:0] r1_wdata,
  output logic             r0_gnt,
  output logic             r1_gnt,
  output logic             r0_rvalid,
  output logic             r1_rvalid,
  output logic [IM_DW-1:0] rdata,
  output logic [IM_AW-1:0] IM_A,
  output logic [IM_DW-1:0] IM_D,
  output logic             IM_WEN,
  input  logic [IM_DW-1:0] IM_Q
);

  im_req_t    r0_cmd, r1_cmd, sel_cmd;
  logic       acc0, acc1;
  // Reads issued last cycle, bit N for requester N; memory answers one cycle later.
  logic [1:0] rd_pend;

  rr_pick2 #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .clk   (clk),
    .reset (reset),
    .req0  (r0_req),
    .req1  (r1_req),
    .gnt0  (r0_gnt),
    .gnt1  (r1_gnt)
  );

  assign r0_cmd  = '{we: r0_we, addr: r0_addr, wdata: r0_wdata};
  assign r1_cmd  = '{we: r1_we, addr: r1_addr, wdata: r1_wdata};
  assign acc0    = r0_req & r0_gnt;
  assign acc1    = r1_req & r1_gnt;
  assign sel_cmd = acc1 ? r1_cmd : r0_cmd;
  assign rdata   = IM_Q;

  always_ff @(posedge clk) begin
    if (reset) begin
      IM_A      <= '0;
      IM_D      <= '0;
      IM_WEN    <= IM_WEN_READ;
      rd_pend   <= 2'b00;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      rd_pend   <= {acc1 & ~r1_we, acc0 & ~r0_we};
      r0_rvalid <= rd_pend[0];
      r1_rvalid <= rd_pend[1];
      if (acc0 || acc1) begin
        IM_A   <= sel_cmd.addr;
        IM_D   <= sel_cmd.wdata;
        IM_WEN <= sel_cmd.we ? IM_WEN_WRITE : IM_WEN_READ;
      end else begin
        // Idle cycle: park in read so nothing is written; address and data hold.
        IM_WEN <= IM_WEN_READ;
      end
    end
  end

endmodule

// File: tb/tb_im_arbiter.sv
module tb_im_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rq [2];
  logic        rw [2];
  logic [19:0] ra [2];
  logic [23:0] rd [2];
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [23:0] rdata, IM_D, IM_Q;
  logic [19:0] IM_A;
  logic        IM_WEN;

  always #5 clk = ~clk;

  im_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .r0_req(rq[0]), .r0_we(rw[0]), .r0_addr(ra[0]), .r0_wdata(rd[0]),
    .r1_req(rq[1]), .r1_we(rw[1]), .r1_addr(ra[1]), .r1_wdata(rd[1]),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .IM_A(IM_A), .IM_D(IM_D), .IM_WEN(IM_WEN), .IM_Q(IM_Q)
  );

  // Image memory: unwritten words read back as their own address.
  logic [23:0] env_mem [0:(1<<20)-1];
  always @(posedge clk) begin
    if (IM_WEN == 1'b0) env_mem[IM_A] <= IM_D;
    else                IM_Q <= env_mem[IM_A];
  end

  // Reference model: who owns the port, how long, who went last, and the expected memory image.
  logic [23:0] ref_mem [0:(1<<20)-1];
  int          m_owner, m_last, m_run, m_acc, m_rv_now, m_rv_pend, exp_g;
  logic [23:0] m_rd_now, m_rd_pend, m_d;
  logic [19:0] m_a;
  logic        m_wen;
  int          n_vec, n_err;

  function automatic int pick();
    int o;
    o = m_owner;
    if (o >= 0 && rq[o] && (!rq[1-o] || m_run < MB)) return o;
    if (rq[0] && rq[1]) return (o >= 0) ? 1 - o : 1 - m_last;
    if (rq[0]) return 0;
    if (rq[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_run = 0; m_acc = -1;
    m_rv_now = -1; m_rv_pend = -1; m_rd_now = '0; m_rd_pend = '0;
    m_a = '0; m_d = '0; m_wen = 1'b1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
    end
  endtask

  // Advance one clock and the model with it; inputs may change on return.
  task automatic tick();
    int g;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      g = pick();
      m_rv_now = m_rv_pend; m_rd_now = m_rd_pend; m_rv_pend = -1;
      if (g >= 0) begin
        m_a = ra[g]; m_d = rd[g]; m_wen = !rw[g];
        if (rw[g]) ref_mem[ra[g]] = rd[g];
        else begin m_rv_pend = g; m_rd_pend = ref_mem[ra[g]]; end
        m_run = (g == m_owner) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
        m_owner = g; m_last = g;
      end else begin
        m_wen = 1'b1; m_owner = -1;
      end
      m_acc = g;
    end
    #1;
  endtask

  // Move to the sampling point of the current cycle.
  task automatic settle();
    @(negedge clk);
    exp_g = reset ? -1 : pick();
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_inputs(); rq[0] = 1'b1;
    tick(); tick(); settle();
    n_vec++; if ({r1_gnt, r0_gnt} !== 2'b00) begin n_err++; $display("FAIL rst_gnt got=%b exp=00", {r1_gnt, r0_gnt}); end
    n_vec++; if (IM_WEN !== 1'b1) begin n_err++; $display("FAIL rst_wen got=%b exp=1", IM_WEN); end
    n_vec++; if (IM_A !== 20'h0 || IM_D !== 24'h0) begin n_err++; $display("FAIL rst_ad got=%h/%h exp=0/0", IM_A, IM_D); end
    n_vec++; if ({r1_rvalid, r0_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_rv got=%b exp=00", {r1_rvalid, r0_rvalid}); end
    tick(); reset = 1'b0; clear_inputs(); tick();
  endtask

  task automatic test_read_burst();
    rq[0] = 1'b1; rw[0] = 1'b0; ra[0] = 20'h00010;
    settle();
    n_vec++; if ({r1_gnt, r0_gnt} !== 2'b01) begin n_err++; $display("FAIL rb_gnt_c0 got=%b exp=01", {r1_gnt, r0_gnt}); end
    tick(); ra[0] = 20'h00011; settle();
    n_vec++; if (r0_gnt !== 1'b1) begin n_err++; $display("FAIL rb_gnt_c1 got=%b exp=1", r0_gnt); end
    n_vec++; if (IM_A !== 20'h00010 || IM_WEN !== 1'b1) begin n_err++; $display("FAIL rb_im_c1 got=%h/%b exp=00010/1", IM_A, IM_WEN); end
    tick(); ra[0] = 20'h00012; settle();
    n_vec++; if (r0_gnt !== 1'b1) begin n_err++; $display("FAIL rb_gnt_c2 got=%b exp=1", r0_gnt); end
    n_vec++; if (IM_A !== 20'h00011) begin n_err++; $display("FAIL rb_a_c2 got=%h exp=00011", IM_A); end
    n_vec++; if (r0_rvalid !== 1'b1 || rdata !== 24'h000010) begin n_err++; $display("FAIL rb_rv_c2 got=%b/%h exp=1/000010", r0_rvalid, rdata); end
    tick(); rq[0] = 1'b0; settle();
    n_vec++; if (r0_gnt !== 1'b0 || IM_A !== 20'h00012) begin n_err++; $display("FAIL rb_c3 got=%b/%h exp=0/00012", r0_gnt, IM_A); end
    n_vec++; if (r0_rvalid !== 1'b1 || rdata !== 24'h000011) begin n_err++; $display("FAIL rb_rv_c3 got=%b/%h exp=1/000011", r0_rvalid, rdata); end
    tick(); settle();
    n_vec++; if (r0_rvalid !== 1'b1 || rdata !== 24'h000012) begin n_err++; $display("FAIL rb_rv_c4 got=%b/%h exp=1/000012", r0_rvalid, rdata); end
    n_vec++; if (IM_WEN !== 1'b1 || IM_A !== 20'h00012) begin n_err++; $display("FAIL rb_hold_c4 got=%b/%h exp=1/00012", IM_WEN, IM_A); end
    tick(); settle();
    n_vec++; if (r0_rvalid !== 1'b0) begin n_err++; $display("FAIL rb_rv_c5 got=%b exp=0", r0_rvalid); end
    tick();
  endtask

  task automatic test_write();
    rq[1] = 1'b1; rw[1] = 1'b1; ra[1] = 20'hFFFFF; rd[1] = 24'hABCDEF;
    settle();
    n_vec++; if ({r1_gnt, r0_gnt} !== 2'b10) begin n_err++; $display("FAIL wr_gnt got=%b exp=10", {r1_gnt, r0_gnt}); end
    tick(); clear_inputs(); settle();
    n_vec++; if (IM_A !== 20'hFFFFF || IM_D !== 24'hABCDEF || IM_WEN !== 1'b0) begin n_err++; $display("FAIL wr_im got=%h/%h/%b exp=fffff/abcdef/0", IM_A, IM_D, IM_WEN); end
    tick(); settle();
    n_vec++; if (IM_WEN !== 1'b1 || IM_A !== 20'hFFFFF || IM_D !== 24'hABCDEF) begin n_err++; $display("FAIL wr_after got=%h/%h/%b exp=fffff/abcdef/1", IM_A, IM_D, IM_WEN); end
    tick();
  endtask

  task automatic test_burst_cap();
    logic [1:0] eg;
    reset = 1'b1; clear_inputs(); tick(); tick(); reset = 1'b0;
    rq[0] = 1'b1; ra[0] = 20'h00500; rq[1] = 1'b1; ra[1] = 20'h00600;
    for (int c = 0; c < 12; c++) begin
      settle();
      eg = (((c / 4) % 2) == 0) ? 2'b01 : 2'b10;
      n_vec++; if ({r1_gnt, r0_gnt} !== eg) begin n_err++; $display("FAIL burst c=%0d got=%b exp=%b", c, {r1_gnt, r0_gnt}, eg); end
      tick();
    end
    clear_inputs(); tick(); tick(); tick();
  endtask

  task automatic test_handover();
    rq[0] = 1'b1; rw[0] = 1'b0; ra[0] = 20'h00100;
    settle();
    n_vec++; if ({r1_gnt, r0_gnt} !== 2'b01) begin n_err++; $display("FAIL ho_c0 got=%b exp=01", {r1_gnt, r0_gnt}); end
    tick(); rq[0] = 1'b0; rq[1] = 1'b1; rw[1] = 1'b1; ra[1] = 20'h00200; rd[1] = 24'h5A5A5A;
    settle();
    n_vec++; if ({r1_gnt, r0_gnt} !== 2'b10) begin n_err++; $display("FAIL ho_c1 got=%b exp=10", {r1_gnt, r0_gnt}); end
    n_vec++; if (IM_A !== 20'h00100 || IM_WEN !== 1'b1) begin n_err++; $display("FAIL ho_im_c1 got=%h/%b exp=00100/1", IM_A, IM_WEN); end
    tick(); clear_inputs(); settle();
    n_vec++; if (IM_A !== 20'h00200 || IM_D !== 24'h5A5A5A || IM_WEN !== 1'b0) begin n_err++; $display("FAIL ho_im_c2 got=%h/%h/%b exp=00200/5a5a5a/0", IM_A, IM_D, IM_WEN); end
    n_vec++; if (r0_rvalid !== 1'b1 || rdata !== 24'h000100) begin n_err++; $display("FAIL ho_rv_c2 got=%b/%h exp=1/000100", r0_rvalid, rdata); end
    tick(); tick();
  endtask

  task automatic test_reset_midread();
    rq[0] = 1'b1; rw[0] = 1'b0; ra[0] = 20'h00033;
    settle();
    n_vec++; if (r0_gnt !== 1'b1) begin n_err++; $display("FAIL rmr_gnt got=%b exp=1", r0_gnt); end
    tick(); clear_inputs(); reset = 1'b1;
    tick(); reset = 1'b0; settle();
    n_vec++; if (r0_rvalid !== 1'b0) begin n_err++; $display("FAIL rmr_rv_c2 got=%b exp=0", r0_rvalid); end
    n_vec++; if (IM_WEN !== 1'b1 || IM_A !== 20'h0) begin n_err++; $display("FAIL rmr_im got=%b/%h exp=1/00000", IM_WEN, IM_A); end
    tick(); settle();
    n_vec++; if (r0_rvalid !== 1'b0) begin n_err++; $display("FAIL rmr_rv_c3 got=%b exp=0", r0_rvalid); end
    tick();
  endtask

  task automatic test_read_write();
    rq[0] = 1'b1; rw[0] = 1'b0; ra[0] = 20'h00040;
    settle();
    n_vec++; if (r0_gnt !== 1'b1) begin n_err++; $display("FAIL rw_gnt0 got=%b exp=1", r0_gnt); end
    tick(); rq[0] = 1'b0; rq[1] = 1'b1; rw[1] = 1'b1; ra[1] = 20'h00041; rd[1] = 24'h123456;
    settle();
    n_vec++; if (r1_gnt !== 1'b1) begin n_err++; $display("FAIL rw_gnt1 got=%b exp=1", r1_gnt); end
    tick(); clear_inputs(); settle();
    n_vec++; if (r0_rvalid !== 1'b1 || rdata !== 24'h000040) begin n_err++; $display("FAIL rw_rv got=%b/%h exp=1/000040", r0_rvalid, rdata); end
    n_vec++; if (IM_WEN !== 1'b0 || IM_A !== 20'h00041 || IM_D !== 24'h123456) begin n_err++; $display("FAIL rw_wr got=%b/%h/%h exp=0/00041/123456", IM_WEN, IM_A, IM_D); end
    tick(); settle();
    n_vec++; if (r0_rvalid !== 1'b0 || IM_WEN !== 1'b1) begin n_err++; $display("FAIL rw_after got=%b/%b exp=0/1", r0_rvalid, IM_WEN); end
    tick();
  endtask

  task automatic test_random();
    logic [1:0] eg, erv;
    reset = 1'b1; clear_inputs(); tick(); tick(); reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      settle();
      eg  = {exp_g == 1, exp_g == 0};
      erv = {m_rv_now == 1, m_rv_now == 0};
      n_vec++; if ({r1_gnt, r0_gnt} !== eg) begin n_err++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {r1_gnt, r0_gnt}, eg); end
      n_vec++; if (IM_WEN !== m_wen || IM_A !== m_a) begin n_err++; $display("FAIL rnd_im c=%0d got=%b/%h exp=%b/%h", c, IM_WEN, IM_A, m_wen, m_a); end
      if (m_wen == 1'b0) begin
        n_vec++; if (IM_D !== m_d) begin n_err++; $display("FAIL rnd_d c=%0d got=%h exp=%h", c, IM_D, m_d); end
      end
      n_vec++; if ({r1_rvalid, r0_rvalid} !== erv) begin n_err++; $display("FAIL rnd_rv c=%0d got=%b exp=%b", c, {r1_rvalid, r0_rvalid}, erv); end
      if (m_rv_now >= 0) begin
        n_vec++; if (rdata !== m_rd_now) begin n_err++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, rdata, m_rd_now); end
      end
      tick();
      reset = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < 2; i++) begin
        if (m_acc == i || !rq[i]) begin
          rq[i] = ($urandom_range(0, 3) != 0);
          rw[i] = 1'($urandom_range(0, 1));
          ra[i] = 20'hF0000 | 20'($urandom_range(0, 15));
          rd[i] = 24'($urandom);
        end
      end
    end
    reset = 1'b0; clear_inputs(); tick(); tick(); tick();
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_g = -1;
    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < (1 << 20); i++) begin
      env_mem[i] = {4'h0, 20'(i)};
      ref_mem[i] = {4'h0, 20'(i)};
    end
    model_reset();
    test_reset();
    test_read_burst();
    test_write();
    test_burst_cap();
    test_handover();
    test_reset_midread();
    test_read_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
